// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path and the RGB565 renderer:
// capture FSM encodings, screen geometry defaults and the decimation mask helper.
package wave_pkg;

    localparam int H_VALID_DEF      = 800;
    localparam int V_VALID_DEF      = 480;
    localparam int AUTO_TIMEOUT_DEF = 4096;
    localparam int ADDR_W_DEF       = 10;

    typedef enum logic [1:0] {
        ST_ARMED     = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } wave_state_t;

    // Last decimation count for a given shift: 2^shift - 1.
    function automatic logic [14:0] dec_mask(input logic [3:0] shift);
        logic [15:0] full;
        full = (16'd1 << shift) - 16'd1;
        return full[14:0];
    endfunction

endpackage

// File: rtl/wave_dpram.sv
// Simple dual-port sample RAM holding both ping-pong buffers; the address MSB
// selects the buffer. One write port, one registered read port.
module wave_dpram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/wave_capture_buf.sv
// ADC sample decimator, level trigger and ping-pong record capture; the display
// reads the front buffer by pixel column while the back buffer fills.
module wave_capture_buf
    import wave_pkg::*;
#(
    parameter int H_VALID      = H_VALID_DEF,
    parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        adc_valid,
    input  logic [7:0]  adc_data,
    input  logic [3:0]  dec_shift,
    input  logic [7:0]  trig_level,
    input  logic        trig_falling,
    input  logic        trig_auto,
    input  logic        frame_start,
    input  logic        lcd_de,
    input  logic [10:0] x,
    output logic [7:0]  sample_8b,
    output logic        frame_valid,
    output logic [1:0]  trig_state
);

    localparam int                TW      = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [TW-1:0]     TO_LAST = TW'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(H_VALID - 1);
    localparam logic [10:0]       X_LIMIT = 11'(H_VALID);

    wave_state_t       state_q, state_d;
    logic [14:0]       dec_cnt_q, dec_cnt_d;
    logic [14:0]       dec_max_q, dec_max_d;
    logic [TW-1:0]     timeout_q, timeout_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              front_sel_q, front_sel_d;
    logic              frame_valid_q, frame_valid_d;
    logic              rd_gate_q;

    logic              taken;
    logic              rise_hit, fall_hit, trig_hit;
    logic              ram_we;
    logic [ADDR_W:0]   ram_waddr;
    logic [7:0]        ram_rdata;

    assign taken    = adc_valid && (dec_cnt_q == 15'd0);
    assign rise_hit = prev_valid_q && (prev_q < trig_level) && (adc_data >= trig_level);
    assign fall_hit = prev_valid_q && (prev_q > trig_level) && (adc_data <= trig_level);
    assign trig_hit = trig_falling ? fall_hit : rise_hit;

    always_comb begin
        state_d       = state_q;
        dec_cnt_d     = dec_cnt_q;
        dec_max_d     = dec_max_q;
        timeout_d     = timeout_q;
        wr_addr_d     = wr_addr_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        front_sel_d   = front_sel_q;
        frame_valid_d = frame_valid_q;
        ram_we        = 1'b0;
        ram_waddr     = {~front_sel_q, wr_addr_q};

        // The decimation period is latched at the start of each period, so a
        // dec_shift change only lands once the counter has wrapped.
        if (adc_valid) begin
            if (dec_cnt_q == 15'd0) begin
                dec_max_d = dec_mask(dec_shift);
                dec_cnt_d = (dec_max_d == 15'd0) ? 15'd0 : 15'd1;
            end else if (dec_cnt_q == dec_max_q) begin
                dec_cnt_d = 15'd0;
            end else begin
                dec_cnt_d = dec_cnt_q + 15'd1;
            end
        end

        case (state_q)
            ST_ARMED: begin
                prev_valid_d = 1'b0;
                timeout_d    = '0;
                wr_addr_d    = '0;
                state_d      = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                if (taken) begin
                    if (trig_hit || (trig_auto && (timeout_q == TO_LAST))) begin
                        ram_we    = 1'b1;
                        ram_waddr = {~front_sel_q, {ADDR_W{1'b0}}};
                        wr_addr_d = ADDR_W'(1);
                        state_d   = ST_CAPTURE;
                    end else begin
                        if (timeout_q != TO_LAST) begin
                            timeout_d = timeout_q + TW'(1);
                        end
                        prev_d       = adc_data;
                        prev_valid_d = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (taken) begin
                    ram_we = 1'b1;
                    if (wr_addr_q == WR_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (frame_start) begin
                    front_sel_d   = ~front_sel_q;
                    frame_valid_d = 1'b1;
                    state_d       = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q       <= ST_ARMED;
            dec_cnt_q     <= '0;
            dec_max_q     <= '0;
            timeout_q     <= '0;
            wr_addr_q     <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            front_sel_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            rd_gate_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dec_cnt_q     <= dec_cnt_d;
            dec_max_q     <= dec_max_d;
            timeout_q     <= timeout_d;
            wr_addr_q     <= wr_addr_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            front_sel_q   <= front_sel_d;
            frame_valid_q <= frame_valid_d;
            // Blanking is decided alongside the read address so it lines up with the RAM output.
            rd_gate_q     <= lcd_de && (x < X_LIMIT) && frame_valid_q;
        end
    end

    wave_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk_i   (pclk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (adc_data),
        .raddr_i ({front_sel_q, x[ADDR_W-1:0]}),
        .rdata_o (ram_rdata)
    );

    assign sample_8b   = rd_gate_q ? ram_rdata : 8'd0;
    assign frame_valid = frame_valid_q;
    assign trig_state  = state_q;

endmodule

// File: tb/tb_wave_capture_buf.sv
// Directed and randomized checks of wave_capture_buf against a record model
// built from the driven ADC stream.
module tb_wave_capture_buf;

    localparam int HV = 800;
    localparam int AT = 16;
    localparam int AW = 10;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adc_valid = 1'b0;
    logic [7:0]  adc_data = 8'd0;
    logic [3:0]  dec_shift = 4'd0;
    logic [7:0]  trig_level = 8'd128;
    logic        trig_falling = 1'b0;
    logic        trig_auto = 1'b0;
    logic        frame_start = 1'b0;
    logic        lcd_de = 1'b0;
    logic [10:0] x = 11'd0;
    logic [7:0]  sample_8b;
    logic        frame_valid;
    logic [1:0]  trig_state;

    int checks = 0;
    int errors = 0;
    int exp_rec [HV];
    int drv_q [$];
    int ncap;

    wave_capture_buf #(
        .H_VALID      (HV),
        .AUTO_TIMEOUT (AT),
        .ADDR_W       (AW)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .dec_shift    (dec_shift),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .trig_auto    (trig_auto),
        .frame_start  (frame_start),
        .lcd_de       (lcd_de),
        .x            (x),
        .sample_8b    (sample_8b),
        .frame_valid  (frame_valid),
        .trig_state   (trig_state)
    );

    always #5 pclk = ~pclk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
        for (int c = 0; c < budget && trig_state !== st; c++) @(negedge pclk);
        chk(tag, trig_state, st);
    endtask

    function automatic logic [7:0] gen(input int mode, input int i);
        int t;
        case (mode)
            0, 3: return 8'(i % 256);
            1: begin
                t = i % 200;
                return (t < 100) ? 8'(40 + 2 * t) : 8'(240 - 2 * (t - 100));
            end
            2: return 8'd50;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic do_reset(input bit pulse_fs);
        @(negedge pclk);
        rst_n = 1'b0; adc_valid = 1'b0; adc_data = 8'd0; frame_start = 1'b0;
        lcd_de = 1'b1; x = 11'd5;
        for (int k = 0; k < 4; k++) begin
            frame_start = pulse_fs && (k % 2 == 1);
            @(negedge pclk);
        end
        frame_start = 1'b0;
        chk("rst_state", trig_state, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_sample", sample_8b, 0);
        rst_n = 1'b1; lcd_de = 1'b0;
        wait_state(2'd1, 8, "post_rst_wait_trig");
    endtask

    // Drives a stream until the record is complete, then rebuilds the expected
    // record from the stream: decimate, find the trigger, take HV samples.
    task automatic run_capture(input int mode, input int ds, input bit fall, input int lvl,
                               input bit aut, input bit rand_valid, input bit fs_in_capture,
                               output int n_at_capture);
        int i, trig, cnt, prev, s, step;
        bit pv, hit;
        int taken [$];
        dec_shift = 4'(ds); trig_falling = fall; trig_level = 8'(lvl); trig_auto = aut;
        drv_q.delete();
        i = 0;
        n_at_capture = -1;
        for (int c = 0; c < 40000; c++) begin
            if (trig_state == 2'd2 && n_at_capture < 0) n_at_capture = drv_q.size();
            if (trig_state == 2'd3) break;
            frame_start = fs_in_capture && (trig_state == 2'd2);
            if (!rand_valid || $urandom_range(0, 3) != 0) begin
                adc_valid = 1'b1;
                adc_data = gen(mode, i);
                drv_q.push_back(int'(adc_data));
                i++;
            end else begin
                adc_valid = 1'b0;
            end
            @(negedge pclk);
        end
        adc_valid = 1'b0; frame_start = 1'b0;
        chk("reach_done", trig_state, 3);

        step = 1 << ds;
        for (int j = 0; j < drv_q.size(); j++) if (j % step == 0) taken.push_back(drv_q[j]);
        trig = -1; pv = 0; prev = 0; cnt = 0;
        for (int j = 0; j < taken.size(); j++) begin
            s = taken[j];
            hit = pv && (fall ? (prev > lvl && s <= lvl) : (prev < lvl && s >= lvl));
            if (hit || (aut && cnt == AT - 1)) begin
                trig = j;
                break;
            end
            if (cnt < AT - 1) cnt++;
            prev = s; pv = 1;
        end
        if (trig < 0 || taken.size() < trig + HV) begin
            checks++; errors++;
            $error("FAIL model_record observed=%0d_taken expected=trigger_plus_%0d", taken.size(), HV);
            for (int k = 0; k < HV; k++) exp_rec[k] = -1;
        end else begin
            for (int k = 0; k < HV; k++) exp_rec[k] = taken[trig + k];
            chk("trig_latency", n_at_capture, trig * step + 1);
            chk("taken_count", taken.size(), trig + HV);
        end
    endtask

    task automatic swap_and_check(input bit fv_before);
        repeat (3) @(negedge pclk);
        chk("hold_done", trig_state, 3);
        chk("fv_before_swap", frame_valid, fv_before);
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0;
        chk("swap_state", trig_state, 0);
        chk("fv_after_swap", frame_valid, 1);
    endtask

    task automatic readback(input string tag);
        lcd_de = 1'b1;
        for (int xi = 0; xi < HV; xi++) begin
            x = 11'(xi);
            @(negedge pclk);
            chk($sformatf("%s[%0d]", tag, xi), sample_8b, exp_rec[xi]);
        end
        x = 11'(HV);
        @(negedge pclk);
        chk({tag, "_x_limit"}, sample_8b, 0);
        x = 11'd2047;
        @(negedge pclk);
        chk({tag, "_x_max"}, sample_8b, 0);
        x = 11'd5; lcd_de = 1'b0;
        @(negedge pclk);
        chk({tag, "_de_low"}, sample_8b, 0);
    endtask

    initial begin
        // 1: idle after reset, frame_start has no effect
        do_reset(1'b1);
        lcd_de = 1'b1; x = 11'd3;
        for (int k = 0; k < 20; k++) begin
            frame_start = (k % 4 == 0);
            @(negedge pclk);
        end
        frame_start = 1'b0;
        chk("t1_state", trig_state, 1);
        chk("t1_frame_valid", frame_valid, 0);
        chk("t1_sample", sample_8b, 0);
        lcd_de = 1'b0;

        // 2: rising trigger on a ramp
        do_reset(1'b0);
        run_capture(0, 0, 1'b0, 128, 1'b0, 1'b0, 1'b1, ncap);
        chk("t2_trig_at", ncap, 129);
        swap_and_check(1'b0);
        readback("t2_rd");
        lcd_de = 1'b1; x = 11'd5;
        @(negedge pclk);
        chk("t2_x5", sample_8b, 133);
        lcd_de = 1'b0;

        // 3: falling trigger on a triangle with gapped valid
        do_reset(1'b0);
        run_capture(1, 0, 1'b1, 100, 1'b0, 1'b1, 1'b1, ncap);
        swap_and_check(1'b0);
        readback("t3_rd");
        lcd_de = 1'b1; x = 11'd0;
        @(negedge pclk);
        chk("t3_x0", sample_8b, 100);
        lcd_de = 1'b0;

        // 4: constant input, auto-trigger on the 16th taken sample
        do_reset(1'b0);
        run_capture(2, 0, 1'b0, 100, 1'b1, 1'b0, 1'b0, ncap);
        chk("t4_auto_16th", ncap, 16);
        swap_and_check(1'b0);
        readback("t4_rd");

        // 5: decimate by 4
        do_reset(1'b0);
        run_capture(3, 2, 1'b0, 128, 1'b0, 1'b1, 1'b1, ncap);
        swap_and_check(1'b0);
        readback("t5_rd");
        lcd_de = 1'b1; x = 11'd1;
        @(negedge pclk);
        chk("t5_x1", sample_8b, 132);
        lcd_de = 1'b0;

        // 6: reset mid-capture hides the old front until a new record swaps in
        do_reset(1'b0);
        run_capture(4, 0, 1'b0, 128, 1'b1, 1'b1, 1'b1, ncap);
        swap_and_check(1'b0);
        readback("t6a_rd");
        wait_state(2'd1, 8, "t6_rearmed");
        dec_shift = 4'd0; trig_falling = 1'b0; trig_level = 8'd128; trig_auto = 1'b0;
        begin
            int i;
            i = 0;
            for (int c = 0; c < 600 && trig_state != 2'd2; c++) begin
                adc_valid = 1'b1; adc_data = 8'(i); i++;
                @(negedge pclk);
            end
            chk("t6_capturing", trig_state, 2);
            repeat (399) begin
                adc_data = 8'(i); i++;
                @(negedge pclk);
            end
            adc_valid = 1'b0;
            chk("t6_mid_capture", trig_state, 2);
        end
        do_reset(1'b1);
        lcd_de = 1'b1; x = 11'd5;
        for (int k = 0; k < 8; k++) begin
            frame_start = (k % 3 == 0);
            @(negedge pclk);
        end
        frame_start = 1'b0;
        chk("t6_fv_after_reset", frame_valid, 0);
        chk("t6_sample_after_reset", sample_8b, 0);
        lcd_de = 1'b0;
        run_capture(3, 0, 1'b0, 128, 1'b0, 1'b0, 1'b0, ncap);
        swap_and_check(1'b0);
        readback("t6b_rd");

        // 7: randomized settings
        for (int r = 0; r < 2; r++) begin
            do_reset(1'b0);
            run_capture(4, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(30, 220)), 1'b1, 1'b1, 1'b1, ncap);
            swap_and_check(1'b0);
            readback($sformatf("t7_%0d_rd", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
